// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the dmem load/store unit.
// Size decoding helpers live here so the LSU and its bench agree on one encoding.
package dmem_lsu_pkg;

    localparam int unsigned DMEM_DEPTH  = 8;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned LSU_LATENCY = 2;

    typedef enum logic [1:0] {
        LSU_B = 2'b00,
        LSU_H = 2'b01,
        LSU_W = 2'b10,
        LSU_X = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_RESP   = 2'b10
    } lsu_state_t;

    // Offset of the last byte touched, i.e. nbytes - 1.
    function automatic logic [2:0] lsu_last_offset(input lsu_size_t size);
        unique case (size)
            LSU_B:   return 3'd0;
            LSU_H:   return 3'd1;
            LSU_W:   return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_byte_en(input lsu_size_t size);
        unique case (size)
            LSU_B:   return 4'b0001;
            LSU_H:   return 4'b0011;
            LSU_W:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshakes and the dmem port bundle of the load/store unit.
// slave is the LSU's view; master is the execute stage plus dmem.
interface dmem_lsu_if
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_DEPTH,
    parameter int unsigned DW     = DATA_WIDTH
);

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    lsu_size_t         req_size_i;
    logic              req_signed_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DW-1:0]     req_wdata_i;

    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [DW-1:0]     resp_rdata_o;
    logic              resp_err_o;

    logic [3:0]        dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [DW-1:0]     dmem_wdata_o;
    logic [DW-1:0]     dmem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
        output req_ready_o,
        output resp_valid_o, resp_rdata_o, resp_err_o,
        input  resp_ready_i,
        output dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_rdata_i
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
        input  req_ready_o,
        input  resp_valid_o, resp_rdata_o, resp_err_o,
        output resp_ready_i,
        input  dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_rdata_i
    );

endinterface

// File: rtl/dmem_lsu_load_fmt.sv
// Extracts the low byte/half/word of dmem read data and sign- or zero-extends it.
module lsu_load_fmt
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned DW = DATA_WIDTH
) (
    input  lsu_size_t     size_i,
    input  logic          sign_ext_i,
    input  logic [DW-1:0] rdata_i,
    output logic [DW-1:0] data_o
);

    always_comb begin
        data_o = '0;
        unique case (size_i)
            LSU_B:   data_o = {{(DW-8){sign_ext_i & rdata_i[7]}}, rdata_i[7:0]};
            LSU_H:   data_o = {{(DW-16){sign_ext_i & rdata_i[15]}}, rdata_i[15:0]};
            LSU_W:   data_o = rdata_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store unit in front of dmem: accept, one access cycle, hold response.
// Accesses whose last byte would run past the top of memory are flagged and never issued.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_DEPTH,
    parameter int unsigned DW     = DATA_WIDTH
) (
    input logic       clk,
    input logic       rst_n,
    dmem_lsu_if.slave bus
);

    lsu_state_t        state_q;
    logic              we_q;
    logic              signed_q;
    logic              err_q;
    lsu_size_t         size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DW-1:0]     wdata_q;

    logic [3:0]        dmem_we_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DW-1:0]     resp_rdata_q;

    logic              accept;
    logic              req_err;
    logic [ADDR_W:0]   last_addr;
    logic [DW-1:0]     load_data;

    assign accept = bus.req_valid_i && (state_q == LSU_IDLE);

    // Carry out of the extra top bit means the access would wrap inside dmem.
    assign last_addr = {1'b0, bus.req_addr_i} + (ADDR_W+1)'(lsu_last_offset(bus.req_size_i));
    assign req_err   = (bus.req_size_i == LSU_X) || last_addr[ADDR_W];

    lsu_load_fmt #(
        .DW(DW)
    ) u_load_fmt (
        .size_i    (size_q),
        .sign_ext_i(signed_q),
        .rdata_i   (bus.dmem_rdata_i),
        .data_o    (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LSU_IDLE;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= LSU_B;
            addr_q       <= '0;
            wdata_q      <= '0;
            dmem_we_q    <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                LSU_IDLE: begin
                    if (accept) begin
                        we_q      <= bus.req_we_i;
                        signed_q  <= bus.req_signed_i;
                        size_q    <= bus.req_size_i;
                        addr_q    <= bus.req_addr_i;
                        wdata_q   <= bus.req_wdata_i;
                        err_q     <= req_err;
                        dmem_we_q <= (bus.req_we_i && !req_err) ?
                                     lsu_byte_en(bus.req_size_i) : 4'b0000;
                        state_q   <= LSU_ACCESS;
                    end
                end
                LSU_ACCESS: begin
                    // dmem_rdata_i was refreshed on this cycle's negedge.
                    dmem_we_q    <= 4'b0000;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= (we_q || err_q) ? '0 : load_data;
                    state_q      <= LSU_RESP;
                end
                LSU_RESP: begin
                    if (bus.resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        state_q      <= LSU_IDLE;
                    end
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = (state_q == LSU_IDLE);
    assign bus.dmem_we_o    = dmem_we_q;
    assign bus.dmem_addr_o  = addr_q;
    assign bus.dmem_wdata_o = wdata_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-array dmem model, directed vector table, corner sequences
// and random transactions checked against a byte-level reference memory.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int AW   = DMEM_DEPTH;
    localparam int MEMN = 1 << AW;
    localparam int TOP  = MEMN - 1;
    localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2, SX = 2'd3;

    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic          sgn;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } req_t;

    typedef struct {
        req_t        r;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if bus ();

    dmem_lsu dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [7:0] mem     [MEMN] = '{default: 8'h00};
    logic [7:0] mem_ref [MEMN] = '{default: 8'h00};

    // dmem: negedge-registered read, byte-lane writes to addr+k with wrap.
    always @(negedge clk) begin
        bus.dmem_rdata_i <= {mem[bus.dmem_addr_o + AW'(3)], mem[bus.dmem_addr_o + AW'(2)],
                             mem[bus.dmem_addr_o + AW'(1)], mem[bus.dmem_addr_o]};
        for (int k = 0; k < 4; k++)
            if (bus.dmem_we_o[k]) mem[bus.dmem_addr_o + AW'(k)] <= bus.dmem_wdata_o[8*k +: 8];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < MEMN; i++) if (mem[i] !== mem_ref[i]) d++;
        return d;
    endfunction

    // Reference: whole access as byte arithmetic on mem_ref.
    function automatic void model(input req_t r, output logic [31:0] rdata, output logic err);
        int nb;
        int a;
        longint val;
        a = int'(r.addr);
        case (r.size)
            2'd0:    nb = 1;
            2'd1:    nb = 2;
            2'd2:    nb = 4;
            default: nb = 0;
        endcase
        err = (nb == 0) || (a + nb - 1 > TOP);
        rdata = '0;
        if (!err) begin
            if (r.we) begin
                for (int k = 0; k < nb; k++) mem_ref[a+k] = r.wdata[8*k +: 8];
            end else begin
                val = 0;
                for (int k = 0; k < nb; k++) val += longint'(mem_ref[a+k]) << (8*k);
                if (r.sgn && nb < 4 && val >= (longint'(1) << (8*nb-1)))
                    val -= longint'(1) << (8*nb);
                rdata = val[31:0];
            end
        end
    endfunction

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input int addr, input logic [31:0] wdata,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.r.we = we; v.r.size = size; v.r.sgn = sgn; v.r.addr = AW'(addr); v.r.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic drive(input req_t r);
        bus.req_we_i     = r.we;
        bus.req_size_i   = lsu_size_t'(r.size);
        bus.req_signed_i = r.sgn;
        bus.req_addr_i   = r.addr;
        bus.req_wdata_i  = r.wdata;
        bus.req_valid_i  = 1'b1;
    endtask

    // Starts and ends at a negedge with the DUT idle (unless nxt is left pending).
    task automatic run_txn(input req_t r, input logic [3:0] exp_we, input int hold,
                           input bit has_next, input req_t nxt,
                           output logic [31:0] rdata, output logic err);
        int waitc = 0;
        drive(r);
        bus.resp_ready_i = 1'b0;
        while (!bus.req_ready_o && waitc < 10) begin @(negedge clk); waitc++; end
        check("req_ready_idle", 32'(bus.req_ready_o), 1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("access_we", 32'(bus.dmem_we_o), 32'(exp_we));
        check("access_addr", 32'(bus.dmem_addr_o), 32'(r.addr));
        check("access_wdata", bus.dmem_wdata_o, r.wdata);
        check("access_busy", 32'({bus.req_ready_o, bus.resp_valid_o}), 0);
        @(negedge clk);
        check("resp_valid", 32'(bus.resp_valid_o), 1);
        check("resp_we_clear", 32'(bus.dmem_we_o), 0);
        rdata = bus.resp_rdata_o;
        err   = bus.resp_err_o;
        for (int i = 0; i < hold; i++) begin
            if (has_next && i == 0) drive(nxt);
            @(negedge clk);
            check("bp_valid", 32'(bus.resp_valid_o), 1);
            check("bp_rdata", bus.resp_rdata_o, rdata);
            check("bp_err", 32'(bus.resp_err_o), 32'(err));
            check("bp_ready", 32'(bus.req_ready_o), 0);
            check("bp_addr_hold", 32'(bus.dmem_addr_o), 32'(r.addr));
            check("bp_we", 32'(bus.dmem_we_o), 0);
        end
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        check("resp_done", 32'({bus.resp_valid_o, bus.req_ready_o}), 32'b01);
        bus.resp_ready_i = 1'b0;
    endtask

    task automatic apply(input req_t r, input int hold, input bit has_next, input req_t nxt,
                         input bit use_model, input logic [31:0] er, input logic ee);
        logic [31:0] mr, ar;
        logic        me, ae;
        logic [3:0]  exp_we;
        model(r, mr, me);
        exp_we = (r.we && !me) ? ((r.size == SB) ? 4'h1 : (r.size == SH) ? 4'h3 : 4'hF) : 4'h0;
        run_txn(r, exp_we, hold, has_next, nxt, ar, ae);
        check("resp_rdata", ar, use_model ? mr : er);
        check("resp_err", 32'(ae), 32'(use_model ? me : ee));
        check("mem_contents", 32'(mem_diffs()), 0);
    endtask

    vec_t vecs[$];
    req_t none;
    req_t rq;
    req_t rn;
    logic [31:0] mr;
    logic me;

    initial begin
        none = '{we: 1'b0, size: SB, sgn: 1'b0, addr: '0, wdata: '0};
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = LSU_B;
        bus.req_signed_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
        bus.resp_ready_i = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready_o), 1);
        check("rst_resp", 32'({bus.resp_valid_o, bus.resp_err_o}), 0);
        check("rst_rdata", bus.resp_rdata_o, 0);
        check("rst_dmem", 32'({bus.dmem_we_o, bus.dmem_addr_o}), 0);
        check("rst_wdata", bus.dmem_wdata_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs.push_back(mk(1, SW, 0, 'h10, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk(0, SW, 1, 'h10, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, SW, 0, 'h10, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, SW, 0, 'h20, 32'hA5A5A5A5, 32'h0, 0));
        vecs.push_back(mk(1, SB, 0, 'h21, 32'h12345680, 32'h0, 0));
        vecs.push_back(mk(0, SB, 1, 'h21, 32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, SB, 0, 'h21, 32'h0, 32'h00000080, 0));
        vecs.push_back(mk(0, SW, 0, 'h20, 32'h0, 32'hA5A580A5, 0));
        vecs.push_back(mk(1, SH, 0, 'h33, 32'hFFFF1234, 32'h0, 0));
        vecs.push_back(mk(0, SH, 0, 'h33, 32'h0, 32'h00001234, 0));
        vecs.push_back(mk(0, SB, 0, 'h33, 32'h0, 32'h00000034, 0));
        vecs.push_back(mk(0, SB, 0, 'h34, 32'h0, 32'h00000012, 0));
        vecs.push_back(mk(0, SH, 1, 'h33, 32'h0, 32'h00001234, 0));
        vecs.push_back(mk(1, SH, 0, 'h00, 32'h0000BEEF, 32'h0, 0));
        vecs.push_back(mk(1, SW, 0, TOP - 1, 32'h11223344, 32'h0, 1));
        vecs.push_back(mk(0, SH, 1, 'h00, 32'h0, 32'hFFFFBEEF, 0));
        vecs.push_back(mk(1, SB, 0, TOP, 32'h0000005A, 32'h0, 0));
        vecs.push_back(mk(0, SB, 0, TOP, 32'h0, 32'h0000005A, 0));
        vecs.push_back(mk(0, SH, 0, TOP, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, SW, 0, TOP - 3, 32'h0, 32'h5A000000, 0));
        vecs.push_back(mk(0, SW, 0, TOP - 2, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, SX, 0, 'h40, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, SX, 0, 'h40, 32'hFFFFFFFF, 32'h0, 1));
        vecs.push_back(mk(0, SW, 0, 'h40, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, SH, 0, TOP - 1, 32'h00007788, 32'h0, 0));
        vecs.push_back(mk(0, SW, 0, TOP - 3, 32'h0, 32'h77880000, 0));
        foreach (vecs[i]) apply(vecs[i].r, 0, 1'b0, none, 1'b0, vecs[i].exp_rdata, vecs[i].exp_err);

        // Back-pressure with the next request already waiting.
        rq = '{we: 1'b0, size: SW, sgn: 1'b0, addr: AW'('h10), wdata: 32'h0};
        rn = '{we: 1'b1, size: SW, sgn: 1'b0, addr: AW'('h60), wdata: 32'h0BADF00D};
        apply(rq, 5, 1'b1, rn, 1'b0, 32'hDEADBEEF, 1'b0);
        apply(rn, 0, 1'b0, none, 1'b0, 32'h0, 1'b0);

        // Reset in the ACCESS cycle of a store: write lands, response is dropped.
        rq = '{we: 1'b1, size: SW, sgn: 1'b0, addr: AW'('h50), wdata: 32'hCAFEF00D};
        model(rq, mr, me);
        drive(rq);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("rst_mid_we", 32'(bus.dmem_we_o), 32'hF);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(bus.req_ready_o), 1);
        check("rst_mid_resp", 32'({bus.resp_valid_o, bus.resp_err_o}), 0);
        check("rst_mid_rdata", bus.resp_rdata_o, 0);
        check("rst_mid_dmem", 32'({bus.dmem_we_o, bus.dmem_addr_o}), 0);
        check("rst_mid_wdata", bus.dmem_wdata_o, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_no_resp", 32'(bus.resp_valid_o), 0);
        end
        check("rst_mid_mem", 32'(mem_diffs()), 0);
        rq = '{we: 1'b0, size: SW, sgn: 1'b1, addr: AW'('h50), wdata: 32'h0};
        apply(rq, 0, 1'b0, none, 1'b0, 32'hCAFEF00D, 1'b0);

        for (int i = 0; i < 150; i++) begin
            rq.we    = 1'($urandom_range(0, 1));
            rq.size  = 2'($urandom_range(0, 3));
            rq.sgn   = 1'($urandom_range(0, 1));
            rq.addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(TOP - 5, TOP))
                                                    : AW'($urandom_range(0, TOP));
            rq.wdata = $urandom;
            apply(rq, int'($urandom_range(0, 2)), 1'b0, none, 1'b1, 32'h0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting directly upstream of `dmem`. It accepts one memory request at a time from the execute stage over a valid/ready handshake and drives `dmem`'s byte-enable, address and write-data ports. It then captures `dmem`'s negedge-registered read data, sign- or zero-extends it, and returns a response over a second valid/ready handshake. Accesses that would run past the top of memory are flagged, never performed.

## Interface
Parameters
- `ADDR_W`, default `DMEM_DEPTH`: byte-address width; equals the `dmem` address width.
- `DW`, default `DATA_WIDTH` (32): request and response data width.

Ports
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  `lsu_size_t`: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed_i`  in  1  sign-extend load data.
- `req_addr_i`  in  ADDR_W  byte address; misalignment is allowed.
- `req_wdata_i`  in  DW  store data, least-significant bytes used.
- `resp_valid_o`  out  1  response present.
- `resp_ready_i`  in  1  response consumed.
- `resp_rdata_o`  out  DW  extended load data; 0 for stores and errors.
- `resp_err_o`  out  1  illegal size or out-of-range access.
- `dmem_we_o`  out  4  to `dmem` `we_i`.
- `dmem_addr_o`  out  ADDR_W  to `dmem` `addr_i`.
- `dmem_wdata_o`  out  DW  to `dmem` `wdata_i`.
- `dmem_rdata_i`  in  DW  from `dmem` `rdata_o`.

## Operation
- FSM `IDLE` → `ACCESS` → `RESP` → `IDLE`.
- `req_ready_o` = (state == `IDLE`). Only one request is outstanding at a time.
- On accept, register `addr`, `we`, `size`, `signed` and `wdata`, and compute `err`.
  - Set `err` if size = 11, or if `addr + nbytes - 1` exceeds 2^ADDR_W − 1. `nbytes` is 1, 2 or 4.
  - This prevents the `addr+k` wrap inside `dmem`.
- Byte enables:
  - byte = 0001, half = 0011, word = 1111.
  - 0000 if the access is a load or `err` is set.
- `ACCESS` state:
  - `dmem_we_o` carries the enables for exactly this one cycle.
  - `dmem_addr_o` is the registered address.
  - `dmem_wdata_o` is the registered wdata unchanged; lane k goes to entry `addr+k`.
- Load formatting:
  - byte uses `rdata[7:0]`; half uses `rdata[15:0]`; word uses all 32 bits.
  - Sign-extend when `signed` is set, else zero-extend.
  - `signed` is ignored for words.
- `RESP` state: hold `resp_valid_o`, `resp_rdata_o` and `resp_err_o` stable until `resp_ready_i` is high, then return to `IDLE`.
- Stores also produce a response, with `resp_rdata_o` = 0.

## Timing
- Accept at posedge ending cycle N → `ACCESS` in N+1.
  - `dmem` samples address and enables at the negedge of N+1.
  - Read data is registered at the posedge ending N+1.
  - `resp_valid_o` is high from cycle N+2.
- Minimum request-to-request spacing is 3 cycles. There is no request/response overlap.
- `dmem_addr_o` and `dmem_wdata_o` hold their last value outside `ACCESS`. `dmem_we_o` is 0 outside `ACCESS`.
- Reset values: state `IDLE`, `req_ready_o` 1 from the cycle after reset, `resp_valid_o` 0, `resp_err_o` 0, `resp_rdata_o` 0, `dmem_we_o` 0, `dmem_addr_o` 0, `dmem_wdata_o` 0.
- Reset asserted during `ACCESS`: the write on that cycle's negedge still completes because `dmem` has no reset. No response is produced, and the FSM is in `IDLE` after the reset edge.
- Reset during `RESP`: the pending response is dropped.
- `req_valid_i` while not ready: ignored. The requester must hold it.

## Structure
- Add to `wi23_defs`:
  - `typedef enum logic [1:0] lsu_size_t` (`LSU_B`, `LSU_H`, `LSU_W`, `LSU_X`).
  - `lsu_state_t`.
  - `LSU_LATENCY = 2`.
- Sub-module `lsu_load_fmt`: combinational extraction and extension of `dmem_rdata_i` by size/signed. This is the only sub-module.
- FSM, request registers and range check live in `dmem_lsu`.

## Test plan
- Store word 0xDEADBEEF @0x10, then load word signed @0x10. Required: `dmem_we_o` = 1111 for one cycle, `resp_rdata_o` = 0xDEADBEEF at N+2.
- Store byte 0x80 @0x21, then load byte @0x21. Required: signed → 0xFFFFFF80, unsigned → 0x00000080, and neighbouring bytes 0x20/0x22 unchanged.
- Misaligned half: store 0x1234 @0x33, then load half unsigned. Required: 0x00001234 in entries 0x33=0x34, 0x34=0x12.
- Top of memory: word store @2^ADDR_W−2. Required: `dmem_we_o` stays 0000, `resp_err_o` = 1, and entries 0/1 are unchanged. Byte store @2^ADDR_W−1 succeeds.
- Back-pressure: hold `resp_ready_i` = 0 for 5 cycles. Required: response stable, `req_ready_o` = 0 throughout, and a new request is accepted only in the cycle after the response handshake.
- Reset mid-access: `rst_n` low in `ACCESS` of a store. Required: memory is written, no `resp_valid_o`, all outputs at reset values next cycle.
